// File: rtl/keypad_scan_4x4.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_4x4
// Purpose  : 4x4 matrix keypad scanner with frame-level debounce and one-cycle
//            key events carrying a {col,row} key code.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_4x4 #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ROW_IN,
    output logic [3:0] COL_OUT,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam int              c_PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX  = c_PW'(SCAN_DIV - 1);
    localparam logic [c_PW-1:0] c_PRESC_ONE  = c_PW'(1);
    localparam logic [3:0]      c_DEB        = 4'(DEBOUNCE);
    // Candidate encoding: bit 4 clear = single key {col,row}; set = NONE/MULTI
    localparam logic [4:0]      c_CAND_NONE  = 5'b10000;
    localparam logic [4:0]      c_CAND_MULTI = 5'b10001;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_t;

    logic [3:0]      r_row_meta;
    logic [3:0]      r_row_sync;
    logic [c_PW-1:0] r_presc;
    col_state_t      r_col_state;
    col_state_t      w_col_next;
    logic [15:0]     r_frame;
    logic [15:0]     w_frame_full;
    logic [3:0]      w_col_base;
    logic [4:0]      r_prev_cand;
    logic [3:0]      r_stab_cnt;
    logic            w_scan_tick;
    logic            w_frame_end;
    logic [4:0]      w_closed_cnt;
    logic [3:0]      w_closed_idx;
    logic [4:0]      w_cand;
    logic            w_match;
    logic [3:0]      w_cnt_next;
    logic            w_reach;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= '0;
            r_row_sync <= '0;
        end else begin
            r_row_meta <= ROW_IN;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_scan_tick = (r_presc == c_PRESC_MAX);
    assign w_frame_end = w_scan_tick && (r_col_state == COL3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_scan_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_state <= COL0;
        end else begin
            r_col_state <= w_col_next;
        end
    end

    always_comb begin
        w_col_next = r_col_state;
        COL_OUT    = 4'b1110;
        case (r_col_state)
            COL0: begin
                COL_OUT = 4'b1110;
                if (w_scan_tick) w_col_next = COL1;
            end
            COL1: begin
                COL_OUT = 4'b1101;
                if (w_scan_tick) w_col_next = COL2;
            end
            COL2: begin
                COL_OUT = 4'b1011;
                if (w_scan_tick) w_col_next = COL3;
            end
            COL3: begin
                COL_OUT = 4'b0111;
                if (w_scan_tick) w_col_next = COL0;
            end
            default: begin
                COL_OUT    = 4'b1110;
                w_col_next = COL0;
            end
        endcase
    end

    // The accumulator holds active-high "closed" bits at index col*4+row
    assign w_col_base = {r_col_state, 2'b00};

    always_comb begin
        w_frame_full = r_frame;
        w_frame_full[w_col_base +: 4] = ~r_row_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
        end else if (w_frame_end) begin
            r_frame <= '0;
        end else if (w_scan_tick) begin
            r_frame <= w_frame_full;
        end
    end

    always_comb begin
        w_closed_cnt = '0;
        w_closed_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame_full[i]) begin
                w_closed_cnt = w_closed_cnt + 5'd1;
                w_closed_idx = 4'(i);
            end
        end
        if (w_closed_cnt == 5'd0) begin
            w_cand = c_CAND_NONE;
        end else if (w_closed_cnt == 5'd1) begin
            w_cand = {1'b0, w_closed_idx};
        end else begin
            w_cand = c_CAND_MULTI;
        end
        w_match = (w_cand == r_prev_cand);
        if (!w_match) begin
            w_cnt_next = 4'd1;
        end else if (r_stab_cnt >= c_DEB) begin
            w_cnt_next = c_DEB;
        end else begin
            w_cnt_next = r_stab_cnt + 4'd1;
        end
        // Only the transition into DEBOUNCE fires; a saturated run stays silent
        w_reach = (w_cnt_next == c_DEB) && (r_stab_cnt != c_DEB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stab_cnt  <= '0;
            r_prev_cand <= c_CAND_NONE;
            key_valid   <= 1'b0;
            key_code    <= 4'h0;
            key_down    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (w_frame_end) begin
                r_stab_cnt  <= w_cnt_next;
                r_prev_cand <= w_cand;
                if (w_reach) begin
                    if (!w_cand[4] && !key_down) begin
                        key_code  <= w_cand[3:0];
                        key_down  <= 1'b1;
                        key_valid <= 1'b1;
                    end else if ((w_cand == c_CAND_NONE) && key_down) begin
                        key_down <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_4x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_4x4
// Purpose  : Self-checking bench for keypad_scan_4x4 with a keypad matrix model
//            and a scoreboard of expected key events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_4x4;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int LAT      = 4 * FRAME + 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  ROW_IN;
    logic [3:0]  COL_OUT;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;

    logic [15:0] keys = '0;
    logic [3:0]  exp_q[$];
    logic        prev_kv = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    keypad_scan_4x4 #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ROW_IN    (ROW_IN),
        .COL_OUT   (COL_OUT),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Matrix model: a closed key (c,r) pulls row r low while column c is driven low
    always_comb begin
        ROW_IN = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !COL_OUT[c]) ROW_IN[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (key_valid) begin
            n_cmp++;
            if (prev_kv) begin
                n_err++;
                $display("FAIL key_valid_width: got high on consecutive cycles, required single-cycle pulse");
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_key_valid: got event code=%h, required no event", key_code);
            end else begin
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    n_err++;
                    $display("FAIL event_code: got %h, required %h", key_code, e);
                end
            end
        end
        prev_kv = key_valid;
    end

    task automatic test_reset();
        logic [3:0] exp_col;
        logic [3:0] one;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (COL_OUT !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b, required 1110", COL_OUT); end
        n_cmp++; if (key_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b, required 0", key_valid); end
        n_cmp++; if (key_code !== 4'h0)   begin n_err++; $display("FAIL reset_code: got %h, required 0", key_code); end
        n_cmp++; if (key_down !== 1'b0)   begin n_err++; $display("FAIL reset_down: got %b, required 0", key_down); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (COL_OUT !== 4'b1101) begin n_err++; $display("FAIL mid_scan_col: got %b, required 1101", COL_OUT); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (COL_OUT !== 4'b1110) begin n_err++; $display("FAIL async_reset_col: got %b, required 1110", COL_OUT); end
        @(negedge clk);
        rst_n = 1'b1;
        one = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(one << (i / 4));
            n_cmp++;
            if (COL_OUT !== exp_col) begin
                n_err++;
                $display("FAIL col_sequence[%0d]: got %b, required %b", i, COL_OUT, exp_col);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_press();
        keys = '0;
        repeat (2 * FRAME) @(negedge clk);
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        for (int i = 0; i < LAT && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL press_event: got %0d pending, required 0 within %0d clk", exp_q.size(), LAT); end
        n_cmp++; if (key_code !== 4'h9)  begin n_err++; $display("FAIL press_code: got %h, required 9", key_code); end
        n_cmp++; if (key_down !== 1'b1)  begin n_err++; $display("FAIL press_down: got %b, required 1", key_down); end
        repeat (10 * FRAME) @(negedge clk);
        n_cmp++; if (key_down !== 1'b1)  begin n_err++; $display("FAIL held_down: got %b, required 1", key_down); end
        keys = '0;
        for (int i = 0; i < LAT && key_down !== 1'b0; i++) @(negedge clk);
        n_cmp++; if (key_down !== 1'b0)  begin n_err++; $display("FAIL release_down: got %b, required 0", key_down); end
        repeat (2 * FRAME) @(negedge clk);
        n_cmp++; if (key_code !== 4'h9)  begin n_err++; $display("FAIL release_code_held: got %h, required 9", key_code); end
    endtask

    task automatic test_bounce();
        logic seen_down;
        seen_down = 1'b0;
        for (int i = 0; i < 8 * FRAME; i++) begin
            if (i % 6 == 0) keys[0] = ~keys[0];
            if (key_down !== 1'b0) seen_down = 1'b1;
            @(negedge clk);
        end
        keys = '0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            if (key_down !== 1'b0) seen_down = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen_down)         begin n_err++; $display("FAIL bounce_down: got key_down high, required 0 throughout"); end
        n_cmp++; if (key_code !== 4'h9) begin n_err++; $display("FAIL bounce_code: got %h, required 9", key_code); end
    endtask

    task automatic test_two_keys();
        logic seen_down;
        seen_down = 1'b0;
        keys = '0;
        keys[6]  = 1'b1;
        keys[12] = 1'b1;
        for (int i = 0; i < 10 * FRAME; i++) begin
            if (key_down !== 1'b0) seen_down = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen_down)         begin n_err++; $display("FAIL multi_down: got key_down high, required 0"); end
        n_cmp++; if (key_code !== 4'h9) begin n_err++; $display("FAIL multi_code: got %h, required 9", key_code); end
        exp_q.push_back(4'h6);
        keys[12] = 1'b0;
        for (int i = 0; i < LAT && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drop_event: got %0d pending, required 0", exp_q.size()); end
        n_cmp++; if (key_code !== 4'h6) begin n_err++; $display("FAIL drop_code: got %h, required 6", key_code); end
        n_cmp++; if (key_down !== 1'b1) begin n_err++; $display("FAIL drop_down: got %b, required 1", key_down); end
        keys = '0;
        for (int i = 0; i < LAT && key_down !== 1'b0; i++) @(negedge clk);
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL drop_release: got %b, required 0", key_down); end
    endtask

    task automatic test_roll_over();
        logic seen_up;
        keys = '0;
        keys[3] = 1'b1;
        exp_q.push_back(4'h3);
        for (int i = 0; i < LAT && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL roll_first_event: got %0d pending, required 0", exp_q.size()); end
        n_cmp++; if (key_code !== 4'h3) begin n_err++; $display("FAIL roll_first_code: got %h, required 3", key_code); end
        keys = '0;
        keys[10] = 1'b1;
        seen_up = 1'b0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            if (key_down !== 1'b1) seen_up = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen_up)           begin n_err++; $display("FAIL roll_down_held: got key_down low, required 1 throughout"); end
        n_cmp++; if (key_code !== 4'h3) begin n_err++; $display("FAIL roll_code_held: got %h, required 3", key_code); end
        keys = '0;
        repeat (4 * FRAME) @(negedge clk);
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL roll_release: got %b, required 0", key_down); end
        keys[10] = 1'b1;
        exp_q.push_back(4'hA);
        for (int i = 0; i < LAT && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL roll_second_event: got %0d pending, required 0", exp_q.size()); end
        n_cmp++; if (key_code !== 4'hA) begin n_err++; $display("FAIL roll_second_code: got %h, required A", key_code); end
        keys = '0;
        for (int i = 0; i < LAT && key_down !== 1'b0; i++) @(negedge clk);
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL roll_final_release: got %b, required 0", key_down); end
    endtask

    task automatic test_reset_during_hold();
        keys = '0;
        keys[15] = 1'b1;
        exp_q.push_back(4'hF);
        for (int i = 0; i < LAT && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL hold_event: got %0d pending, required 0", exp_q.size()); end
        n_cmp++; if (key_code !== 4'hF) begin n_err++; $display("FAIL hold_code: got %h, required F", key_code); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (COL_OUT !== 4'b1110) begin n_err++; $display("FAIL hold_reset_col: got %b, required 1110", COL_OUT); end
        n_cmp++; if (key_code !== 4'h0)   begin n_err++; $display("FAIL hold_reset_code: got %h, required 0", key_code); end
        n_cmp++; if (key_down !== 1'b0)   begin n_err++; $display("FAIL hold_reset_down: got %b, required 0", key_down); end
        n_cmp++; if (key_valid !== 1'b0)  begin n_err++; $display("FAIL hold_reset_valid: got %b, required 0", key_valid); end
        repeat (5) @(negedge clk);
        exp_q.push_back(4'hF);
        rst_n = 1'b1;
        for (int i = 0; i < LAT && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL post_reset_event: got %0d pending, required 0", exp_q.size()); end
        n_cmp++; if (key_code !== 4'hF) begin n_err++; $display("FAIL post_reset_code: got %h, required F", key_code); end
        n_cmp++; if (key_down !== 1'b1) begin n_err++; $display("FAIL post_reset_down: got %b, required 1", key_down); end
        keys = '0;
        for (int i = 0; i < LAT && key_down !== 1'b0; i++) @(negedge clk);
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL post_reset_release: got %b, required 0", key_down); end
        repeat (2 * FRAME) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_roll_over();
        test_reset_during_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
- Input-side companion to the board's multiplexed seven-segment display driver.
- Scans a 4x4 matrix keypad on a Pmod header by driving one active-low column at a time and sampling the four rows.
- Debounces the result across whole scan frames and emits one-cycle key events with a 4-bit key code.
- Downstream counter and display logic consume those events.

Parameters:
- SCAN_DIV, 100000, clk cycles per column step (1 ms at 100 MHz); legal minimum 4.
- DEBOUNCE, 10, consecutive identical frames required to accept a press or release; legal range 2..15.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- ROW_IN  in  4  keypad rows; asynchronous; pulled up; low = key closed in the driven column
- COL_OUT  out  4  column drive, active-low one-hot
- key_valid  out  1  one-cycle pulse on an accepted press
- key_code  out  4  {col_idx[1:0], row_idx[1:0]} of the last accepted key; held between events
- key_down  out  1  high while the accepted key is debounced-held

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - COL_OUT=4'b1110, key_valid=0, key_code=4'h0, key_down=0.
  - Prescaler, col_idx, synchroniser, frame accumulator and stability counter all cleared.
  - Previous-candidate register = NONE.
- ROW_IN synchronisation: two-flop synchroniser per bit. All decisions use the synchronised rows.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - scan_tick = 1-cycle pulse when count == SCAN_DIV-1.
- Column FSM, states COL0..COL3:
  - COL_OUT = 1110, 1101, 1011, 0111 respectively.
  - On scan_tick: sample synced rows for the current column into the frame accumulator, then advance COL0->COL1->COL2->COL3->COL0.
  - Each column is therefore driven for a full SCAN_DIV cycles before it is sampled.
- Frame evaluation (on the scan_tick that samples COL3):
  - Count the low row bits over all 16 positions.
  - 0 low -> candidate = NONE.
  - Exactly 1 low -> candidate = {col,row}.
  - >1 low -> candidate = MULTI.
  - Accumulator clears for the next frame.
- Stability counter:
  - If candidate == previous candidate, the counter increments, saturating at DEBOUNCE.
  - Otherwise the counter loads 1.
  - Previous candidate is then updated.
  - MULTI never matches any key, so a multi-key frame breaks a key's stability run.
- Accept, evaluated on the frame where the counter reaches exactly DEBOUNCE:
  - candidate = key and key_down=0: key_code<=candidate, key_down<=1, key_valid=1 for exactly one clk (the cycle after the evaluating tick).
  - candidate = NONE and key_down=1: key_down<=0, no key_valid, key_code held.
  - candidate = key while key_down=1 (a key changed without release): no event. A new key requires a debounced release first.
  - candidate = MULTI: no output change.
- Latency:
  - First press event occurs DEBOUNCE to DEBOUNCE+1 frames after the press becomes stable at the synchroniser, plus 1 clk.
  - One frame = 4*SCAN_DIV clk.
- Held key: no repeat events; saturation prevents re-triggering.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A key still held after rst_n rises must be re-debounced and produces a fresh key_valid.
- Widths:
  - Prescaler is clog2(SCAN_DIV) bits; stability counter is 4 bits.
  - No arithmetic overflow is possible: both are explicitly wrapped or saturated.

Test Plan:
(SCAN_DIV=4, DEBOUNCE=3, frame = 16 clk. The bench keypad model pulls ROW_IN[r] low only while COL_OUT[c] is low for a pressed key (c,r).)
- Reset: assert rst_n=0 mid-scan -> COL_OUT=1110, key_valid=0, key_code=0, key_down=0 immediately; after release, COL_OUT steps 1110->1101->1011->0111 every 4 clk.
- Single press (col2,row1) held 10 frames -> exactly one key_valid pulse, key_code=4'h9, key_down=1 within 4 frames of press; release -> key_down=0 within 4 frames, no extra pulse.
- Bounce: toggle key (0,0) every 6 clk for 8 frames, then idle -> no key_valid, key_down stays 0.
- Two keys: (1,2) and (3,0) pressed together for 10 frames -> no key_valid, key_code unchanged. Then drop (3,0) -> one pulse with key_code=4'h6.
- Roll-over: hold (0,3) until accepted (code 4'h3), switch directly to (2,2) for 10 frames -> no new event, key_down=1. Release all 4 frames, then press (2,2) -> key_down falls, then one pulse with code 4'hA.
- Reset during hold: key (3,3) accepted, pulse rst_n low for 5 clk while still held -> outputs cleared; after release of reset, a new key_valid with code 4'hF within 4 frames.
